// File: rtl/nor_n_deglitch.sv
// N-input masked NOR with optional input synchroniser and a counter-based
// deglitch filter. Produces a filtered registered output, a one-cycle change
// strobe and a saturating count of rejected pulses.
module nor_n_deglitch #(
  parameter int unsigned N           = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEGLITCH    = 4,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned MODE        = 0,
  parameter int unsigned GW          = 8,
  parameter bit          RST_VAL     = 1'b1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CELV,
  input  logic          CELG,
  input  logic          SUB,
  input  logic [N-1:0]  i,
  input  logic [N-1:0]  en,
  input  logic          clr_glitch,
  output logic          o,
  output logic          chg,
  output logic [GW-1:0] glitch_cnt
);

  // Parameter legality, rejected at elaboration.
  if (N < 2 || N > 16) begin : g_bad_n
    $error("nor_n_deglitch: N must be in 2..16");
  end
  if (SYNC_STAGES > 3) begin : g_bad_sync
    $error("nor_n_deglitch: SYNC_STAGES must be in 0..3");
  end
  if (DEGLITCH < 1 || DEGLITCH > (2 ** CNT_W) - 1) begin : g_bad_dg
    $error("nor_n_deglitch: DEGLITCH must be in 1..2^CNT_W-1");
  end
  if (MODE > 2) begin : g_bad_mode
    $error("nor_n_deglitch: MODE must be 0, 1 or 2");
  end

  // Counter value on which the DEGLITCH-th consecutive mismatch lands.
  localparam logic [CNT_W-1:0] DgLast  = CNT_W'(DEGLITCH - 1);
  localparam logic [GW-1:0]    GcSat   = {GW{1'b1}};

  // Power/ground/substrate pins carry no logic; fold them so they are consumed.
  logic unused_pins;
  assign unused_pins = CELV ^ CELG ^ SUB;

  // --------------------------------------------------------------------------
  // Input synchroniser
  // --------------------------------------------------------------------------
  logic [N-1:0] in_s;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign in_s = i;
  end else begin : g_sync
    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] sync_d [SYNC_STAGES];

    // Shift chain: stage 0 samples the raw pins, later stages follow.
    always_comb begin
      sync_d[0] = i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_d[s] = sync_q[s-1];
      end
    end

    // Synchroniser flops, cleared on reset so a pending edge is forgotten.
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        for (int s = 0; s < SYNC_STAGES; s++) begin
          sync_q[s] <= '0;
        end
      end else begin
        for (int s = 0; s < SYNC_STAGES; s++) begin
          sync_q[s] <= sync_d[s];
        end
      end
    end

    assign in_s = sync_q[SYNC_STAGES-1];
  end

  // --------------------------------------------------------------------------
  // Masked NOR and edge classification
  // --------------------------------------------------------------------------
  logic raw;
  logic unfilt;

  // en is intentionally not synchronised; a mask change is just another edge.
  assign raw = ~|(in_s & en);

  // raw=1 while o differs means a rising edge of o is pending.
  assign unfilt = raw ? (MODE == 2) : (MODE == 1);

  // --------------------------------------------------------------------------
  // Deglitch filter
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             o_q, o_d;
  logic             chg_q, chg_d;
  logic             glitch;

  // Next-state for the filter counter, output and change strobe.
  always_comb begin
    cnt_d  = '0;
    o_d    = o_q;
    chg_d  = 1'b0;
    glitch = 1'b0;
    if (raw != o_q) begin
      if (unfilt || (cnt_q == DgLast)) begin
        o_d   = raw;
        chg_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      // Mismatch collapsed before reaching DEGLITCH: a rejected pulse.
      glitch = (cnt_q != '0);
    end
  end

  // Filter state registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q <= '0;
      o_q   <= RST_VAL;
      chg_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      o_q   <= o_d;
      chg_q <= chg_d;
    end
  end

  // --------------------------------------------------------------------------
  // Glitch counter
  // --------------------------------------------------------------------------
  logic [GW-1:0] gc_q, gc_d;

  // Saturating increment on each rejected pulse; clear has priority.
  always_comb begin
    gc_d = gc_q;
    if (clr_glitch) begin
      gc_d = '0;
    end else if (glitch && (gc_q != GcSat)) begin
      gc_d = gc_q + 1'b1;
    end
  end

  // Glitch counter register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      gc_q <= '0;
    end else begin
      gc_q <= gc_d;
    end
  end

  assign o          = o_q;
  assign chg        = chg_q;
  assign glitch_cnt = gc_q;

endmodule

// File: tb/tb_nor_n_deglitch.sv
// Directed bench for nor_n_deglitch: default instance, a MODE=1 instance and a
// wide unfiltered instance, all sharing clock and reset.
module tb_nor_n_deglitch;

  logic       CLK;
  logic       RSTN;

  logic [2:0] i_a, en_a;
  logic       clr_a, o_a, chg_a;
  logic [7:0] gc_a;

  logic [2:0] i_m, en_m;
  logic       clr_m, o_m, chg_m;
  logic [7:0] gc_m;

  logic [7:0] i_n, en_n;
  logic       clr_n, o_n, chg_n;
  logic [7:0] gc_n;

  int total;
  int bad;

  nor_n_deglitch u_dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .CELV       (1'b1),
    .CELG       (1'b0),
    .SUB        (1'b0),
    .i          (i_a),
    .en         (en_a),
    .clr_glitch (clr_a),
    .o          (o_a),
    .chg        (chg_a),
    .glitch_cnt (gc_a)
  );

  nor_n_deglitch #(.MODE(1)) u_dut_m1 (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .CELV       (1'b1),
    .CELG       (1'b0),
    .SUB        (1'b0),
    .i          (i_m),
    .en         (en_m),
    .clr_glitch (clr_m),
    .o          (o_m),
    .chg        (chg_m),
    .glitch_cnt (gc_m)
  );

  nor_n_deglitch #(.N(8), .SYNC_STAGES(0), .DEGLITCH(1)) u_dut_n8 (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .CELV       (1'b1),
    .CELG       (1'b0),
    .SUB        (1'b0),
    .i          (i_n),
    .en         (en_n),
    .clr_glitch (clr_n),
    .o          (o_n),
    .chg        (chg_n),
    .glitch_cnt (gc_n)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance n rising edges, landing 1ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTN = 1'b1;
    i_a = '0; en_a = 3'b111; clr_a = 1'b0;
    i_m = '0; en_m = 3'b111; clr_m = 1'b0;
    i_n = '0; en_n = '0;     clr_n = 1'b0;
    #1 RSTN = 1'b0;
    step(3);
    total++;
    if (o_a !== 1'b1 || chg_a !== 1'b0 || gc_a !== 8'd0) begin
      bad++;
      $display("FAIL reset_state: o=%b chg=%b gc=%0d want o=1 chg=0 gc=0", o_a, chg_a, gc_a);
    end
    @(negedge CLK) RSTN = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      total++;
      if (o_a !== 1'b1 || chg_a !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold c%0d: o=%b chg=%b want o=1 chg=0", k, o_a, chg_a);
      end
    end
  endtask

  task automatic test_filtered_edges();
    logic eo;
    logic ec;
    i_a = 3'b010;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      eo = (k >= 6) ? 1'b0 : 1'b1;
      ec = (k == 6);
      total++;
      if (o_a !== eo || chg_a !== ec) begin
        bad++;
        $display("FAIL fall e%0d: o=%b chg=%b want o=%b chg=%b", k, o_a, chg_a, eo, ec);
      end
    end
    step(4);
    i_a = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      eo = (k >= 6) ? 1'b1 : 1'b0;
      ec = (k == 6);
      total++;
      if (o_a !== eo || chg_a !== ec) begin
        bad++;
        $display("FAIL rise e%0d: o=%b chg=%b want o=%b chg=%b", k, o_a, chg_a, eo, ec);
      end
    end
  endtask

  task automatic test_glitch();
    // Single 3-cycle pulse: rejected, counted once.
    i_a = 3'b001;
    step(3);
    i_a = 3'b000;
    for (int k = 4; k <= 8; k++) begin
      step(1);
      total++;
      if (o_a !== 1'b1) begin
        bad++;
        $display("FAIL glitch_hold e%0d: o=%b want 1", k, o_a);
      end
    end
    total++;
    if (gc_a !== 8'd1) begin
      bad++;
      $display("FAIL glitch_one: gc=%0d want 1", gc_a);
    end
    // Saturation.
    for (int p = 0; p < 300; p++) begin
      i_a = 3'b001;
      step(3);
      i_a = 3'b000;
      step(3);
    end
    total++;
    if (gc_a !== 8'd255 || o_a !== 1'b1) begin
      bad++;
      $display("FAIL glitch_sat: gc=%0d o=%b want gc=255 o=1", gc_a, o_a);
    end
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    total++;
    if (gc_a !== 8'd0) begin
      bad++;
      $display("FAIL glitch_clr: gc=%0d want 0", gc_a);
    end
    i_a = 3'b001;
    step(3);
    i_a = 3'b000;
    step(3);
    total++;
    if (gc_a !== 8'd1) begin
      bad++;
      $display("FAIL glitch_after_clr: gc=%0d want 1", gc_a);
    end
    // Clear lands on the same edge as the next glitch.
    i_a = 3'b001;
    step(3);
    i_a = 3'b000;
    step(2);
    total++;
    if (gc_a !== 8'd1) begin
      bad++;
      $display("FAIL glitch_pre_coinc: gc=%0d want 1", gc_a);
    end
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    total++;
    if (gc_a !== 8'd0 || o_a !== 1'b1) begin
      bad++;
      $display("FAIL glitch_clr_wins: gc=%0d o=%b want gc=0 o=1", gc_a, o_a);
    end
  endtask

  task automatic test_mask_mode1();
    logic eo;
    logic ec;
    en_a = 3'b110;
    i_a  = 3'b001;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      total++;
      if (o_a !== 1'b1 || chg_a !== 1'b0) begin
        bad++;
        $display("FAIL mask c%0d: o=%b chg=%b want o=1 chg=0", k, o_a, chg_a);
      end
    end
    i_a  = 3'b000;
    en_a = 3'b111;
    step(4);
    i_m = 3'b010;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      eo = (k >= 3) ? 1'b0 : 1'b1;
      ec = (k == 3);
      total++;
      if (o_m !== eo || chg_m !== ec) begin
        bad++;
        $display("FAIL m1_fall e%0d: o=%b chg=%b want o=%b chg=%b", k, o_m, chg_m, eo, ec);
      end
    end
    i_m = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      eo = (k >= 6) ? 1'b1 : 1'b0;
      ec = (k == 6);
      total++;
      if (o_m !== eo || chg_m !== ec) begin
        bad++;
        $display("FAIL m1_rise e%0d: o=%b chg=%b want o=%b chg=%b", k, o_m, chg_m, eo, ec);
      end
    end
  endtask

  task automatic test_reset_midcount();
    logic eo;
    logic ec;
    i_a = 3'b010;
    step(4);
    #1 RSTN = 1'b0;
    #1;
    total++;
    if (o_a !== 1'b1 || chg_a !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: o=%b chg=%b want o=1 chg=0", o_a, chg_a);
    end
    step(1);
    @(negedge CLK) RSTN = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      eo = (k >= 6) ? 1'b0 : 1'b1;
      ec = (k == 6);
      total++;
      if (o_a !== eo || chg_a !== ec) begin
        bad++;
        $display("FAIL rst_restart e%0d: o=%b chg=%b want o=%b chg=%b", k, o_a, chg_a, eo, ec);
      end
    end
    // Asynchronous reset while o=0 and chg=1.
    #1 RSTN = 1'b0;
    #1;
    total++;
    if (o_a !== 1'b1 || chg_a !== 1'b0 || gc_a !== 8'd0) begin
      bad++;
      $display("FAIL rst_async: o=%b chg=%b gc=%0d want o=1 chg=0 gc=0", o_a, chg_a, gc_a);
    end
    i_a = 3'b000;
    step(1);
    @(negedge CLK) RSTN = 1'b1;
    step(2);
  endtask

  task automatic test_back_to_back();
    logic exp_o;
    logic prev_o;
    logic [7:0] vi;
    logic [7:0] ve;
    prev_o = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      vi = 8'($urandom);
      ve = 8'($urandom);
      i_n  = vi;
      en_n = ve;
      step(1);
      exp_o = ~|(vi & ve);
      total++;
      if (o_n !== exp_o || chg_n !== (exp_o != prev_o)) begin
        bad++;
        $display("FAIL n8 v%0d: o=%b chg=%b want o=%b chg=%b", k, o_n, chg_n, exp_o,
                 exp_o != prev_o);
      end
      prev_o = exp_o;
    end
    total++;
    if (gc_n !== 8'd0) begin
      bad++;
      $display("FAIL n8_glitch: gc=%0d want 0", gc_n);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_filtered_edges();
    test_glitch();
    test_mask_mode1();
    test_reset_midcount();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
